mdu: RTL and testbench
======================

MDU -- requirements
Module: mdu

Interface
REQ-001 The clock and reset SHALL be: one clock; reset is asynchronous and active-high.
REQ-002 Port list (name  direction  width  meaning) SHALL be:
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high
- num1  in  32  operand A, from the same EX operand bus that feeds the ALU
- num2  in  32  operand B, from the same EX operand bus that feeds the ALU
- op  in  3  000 NONE, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 reserved
- start  in  1  accept op this cycle
- hi  out  32  HI register, consumed by the EX result mux beside the ALU result
- lo  out  32  LO register, consumed by the EX result mux beside the ALU result
- busy  out  1  operation in progress; pipeline stalls any HI/LO access while high
- done  out  1  one-cycle pulse after a MULT/MULTU/DIV/DIVU completes
- op_invalid  out  1  one-cycle pulse when start is accepted with op 111
- div_zero  out  1  one-cycle pulse on divide by zero (feature-gated, see Configuration)

Function
REQ-003 The FSM SHALL have states IDLE and BUSY and a 4-bit down-counter cnt.
REQ-004 IDLE with start=1 and op MULT/MULTU SHALL latch both operands, load cnt=4 and enter BUSY; busy is high for exactly 5 cycles.
REQ-005 IDLE with start=1 and op DIV/DIVU SHALL latch both operands, load cnt=9 and enter BUSY; busy is high for exactly 10 cycles.
REQ-006 In BUSY, cnt SHALL decrement each cycle. At cnt=0 the FSM SHALL write hi/lo, return to IDLE and pulse done high in the following cycle.
REQ-007 MULT/MULTU SHALL compute a 64-bit signed or unsigned product; hi gets bits 63:32 and lo gets bits 31:0.
REQ-008 DIV SHALL truncate toward zero; the remainder takes the sign of the dividend; lo gets the quotient and hi gets the remainder.
REQ-009 DIV with 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000 and hi=0 with no flag.
REQ-010 DIVU SHALL perform unsigned division; lo gets the quotient and hi gets the remainder.
REQ-011 MTHI/MTLO with start=1 in IDLE SHALL write num1 to hi or lo on the same edge, with no busy and no done.
REQ-012 Operands SHALL be sampled only on the accepting edge; num1/num2 changes during BUSY SHALL have no effect.
REQ-013 start while BUSY SHALL be ignored: no latch, no flag, no state change.
REQ-014 start with op NONE SHALL do nothing.
REQ-015 start with op 111 SHALL pulse op_invalid for one cycle, leave hi/lo unchanged and stay in IDLE.
REQ-016 hi/lo SHALL hold their value at all times other than the update edges in REQ-006 and REQ-011.

Reset
REQ-017 Reset SHALL immediately force IDLE, cnt=0, hi=0, lo=0 and busy=done=op_invalid=div_zero=0.
REQ-018 Reset asserted mid-operation SHALL abort it with no hi/lo update and no done after release.

Configuration
REQ-019 With MDU_DIV_ZERO_EN defined, DIV/DIVU with num2=0 SHALL pulse div_zero for one cycle on the accepting cycle, leave hi/lo unchanged, skip BUSY and produce no done.
REQ-020 Without MDU_DIV_ZERO_EN, div_zero SHALL be tied to 0 and divide by zero SHALL run the full 10 cycles with result lo=0xFFFFFFFF and hi=num1.

Verification
REQ-021 MULT with num1=0xFFFFFFFE (-2) and num2=3 -> busy high for 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA, done pulse.
REQ-022 MULTU with num1=0xFFFFFFFF and num2=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001 after 5 busy cycles.
REQ-023 DIV with num1=-7 and num2=2 -> after 10 busy cycles lo=0xFFFFFFFD and hi=0xFFFFFFFF.
REQ-024 DIV with 0x80000000 / -1 -> lo=0x80000000 and hi=0.
REQ-025 DIVU with num1=100 and num2=0 -> with MDU_DIV_ZERO_EN: div_zero pulse, hi/lo unchanged, busy stays 0; without it: lo=0xFFFFFFFF and hi=100.
REQ-026 MULT started, a second start issued on busy cycle 2, reset pulsed on cycle 3 -> second start ignored, hi=lo=0, no done afterwards; then MTLO with num1=0x1234 -> lo=0x1234 on the next edge, op 111 -> single op_invalid pulse.

Source files
------------

// File: rtl/mdu.sv
`default_nettype none
// ============================================================================
// Module   : mdu
// Purpose  : Multiply/divide unit holding the architectural HI/LO pair.
//            MULT/MULTU occupy the unit for 5 cycles and DIV/DIVU for 10
//            cycles. When the count expires, HI/LO are written on the same edge
//            that returns the unit to idle, and done pulses in the next cycle.
//            MTHI/MTLO write HI/LO directly on the accepting edge.
// Ports    : clk, reset     - rising-edge clock, async active-high reset
//            num1, num2     - operands A/B from the EX operand bus
//            op, start      - operation code and accept strobe
//            hi, lo         - HI/LO registers
//            busy           - multi-cycle operation in progress
//            done           - one-cycle pulse after a MULT/DIV result is written
//            op_invalid     - one-cycle pulse after op 111 is accepted
//            div_zero       - one-cycle pulse after a divide by zero is trapped
// Config   : MDU_DIV_ZERO_EN - when defined, a divide with num2 == 0 is
//            trapped at accept time: div_zero pulses, HI/LO are untouched and
//            the unit never goes busy. When undefined, div_zero is tied low and
//            a divide by zero runs normally, giving lo = all ones, hi = num1.
// Pulses   : done, op_invalid and div_zero are registered. Each is high for
//            exactly one cycle, starting at the edge that produces it.
// Revision : 1.0 - initial release
// ============================================================================
module mdu (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] num1,
  input  logic [31:0] num2,
  input  logic [2:0]  op,
  input  logic        start,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        op_invalid,
  output logic        div_zero
);

  localparam logic [2:0] OP_NONE  = 3'b000;
  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;
  localparam logic [2:0] OP_RSVD  = 3'b111;

  // The count runs down to zero inclusive, so the busy time is the load value + 1.
  localparam logic [3:0] MUL_CNT = 4'd4;
  localparam logic [3:0] DIV_CNT = 4'd9;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;
  logic        inv_q, inv_d;

  logic        w_div_trap;

`ifdef MDU_DIV_ZERO_EN
  logic        dz_q, dz_d;
  assign w_div_trap = (num2 == 32'd0);
`else
  assign w_div_trap = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Result datapath, evaluated from the latched operands only.
  // --------------------------------------------------------------------------
  logic        w_signed;
  logic        w_is_mul;
  logic [63:0] w_mul_a;
  logic [63:0] w_mul_b;
  logic [63:0] w_prod;
  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [31:0] w_uquot;
  logic [31:0] w_urem;
  logic [31:0] w_quot;
  logic [31:0] w_rem;
  logic [31:0] w_res_hi;
  logic [31:0] w_res_lo;

  assign w_signed = (op_q == OP_MULT) || (op_q == OP_DIV);
  assign w_is_mul = (op_q == OP_MULT) || (op_q == OP_MULTU);

  // The low 64 bits of a 64x64 product of sign-extended operands equal the
  // signed 32x32 product, so one multiplier serves both MULT and MULTU.
  assign w_mul_a = w_signed ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
  assign w_mul_b = w_signed ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
  assign w_prod  = w_mul_a * w_mul_b;

  // Signed division works on magnitudes and then restores the signs. The
  // quotient is negated when the operand signs differ, and the remainder
  // follows the dividend. The magnitude of 0x80000000 is 0x80000000, so
  // 0x80000000 / -1 wraps back to 0x80000000 with a zero remainder.
  assign w_a_neg = w_signed & a_q[31];
  assign w_b_neg = w_signed & b_q[31];
  assign w_a_mag = w_a_neg ? (32'd0 - a_q) : a_q;
  assign w_b_mag = w_b_neg ? (32'd0 - b_q) : b_q;
  assign w_uquot = w_a_mag / w_b_mag;
  assign w_urem  = w_a_mag % w_b_mag;

  always_comb begin
    w_quot = (w_a_neg ^ w_b_neg) ? (32'd0 - w_uquot) : w_uquot;
    w_rem  = w_a_neg ? (32'd0 - w_urem) : w_urem;
    // A zero divisor gives an all-ones quotient, and the dividend passes
    // through as the remainder.
    if (b_q == 32'd0) begin
      w_quot = 32'hFFFF_FFFF;
      w_rem  = a_q;
    end
  end

  assign w_res_hi = w_is_mul ? w_prod[63:32] : w_rem;
  assign w_res_lo = w_is_mul ? w_prod[31:0]  : w_quot;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    inv_d   = 1'b0;
`ifdef MDU_DIV_ZERO_EN
    dz_d    = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (op)
            OP_NONE: ;
            OP_MULT, OP_MULTU: begin
              a_d     = num1;
              b_d     = num2;
              op_d    = op;
              cnt_d   = MUL_CNT;
              state_d = S_BUSY;
            end
            OP_DIV, OP_DIVU: begin
              if (w_div_trap) begin
`ifdef MDU_DIV_ZERO_EN
                dz_d = 1'b1;
`endif
              end else begin
                a_d     = num1;
                b_d     = num2;
                op_d    = op;
                cnt_d   = DIV_CNT;
                state_d = S_BUSY;
              end
            end
            OP_MTHI: hi_d  = num1;
            OP_MTLO: lo_d  = num1;
            OP_RSVD: inv_d = 1'b1;
            default: ;
          endcase
        end
      end

      S_BUSY: begin
        // start is ignored here. Operands were captured at accept time.
        if (cnt_q == 4'd0) begin
          hi_d    = w_res_hi;
          lo_d    = w_res_lo;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      op_q    <= OP_NONE;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      done_q  <= 1'b0;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      inv_q   <= inv_d;
    end
  end

`ifdef MDU_DIV_ZERO_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dz_q <= 1'b0;
    end else begin
      dz_q <= dz_d;
    end
  end
  assign div_zero = dz_q;
`else
  assign div_zero = 1'b0;
`endif

  assign hi         = hi_q;
  assign lo         = lo_q;
  assign busy       = (state_q == S_BUSY);
  assign done       = done_q;
  assign op_invalid = inv_q;

endmodule
`default_nettype wire

// File: tb/tb_mdu.sv
`default_nettype none
// ============================================================================
// Module   : tb_mdu
// Purpose  : Self-checking bench for mdu. The stimulus side computes each
//            expected result with plain 64-bit arithmetic and queues it. A
//            monitor pops and compares an entry whenever done, op_invalid or
//            div_zero pulses. Honors MDU_DIV_ZERO_EN like the design does.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mdu;

  localparam logic [2:0] NONE  = 3'b000;
  localparam logic [2:0] MULT  = 3'b001;
  localparam logic [2:0] MULTU = 3'b010;
  localparam logic [2:0] DIV   = 3'b011;
  localparam logic [2:0] DIVU  = 3'b100;
  localparam logic [2:0] MTHI  = 3'b101;
  localparam logic [2:0] MTLO  = 3'b110;
  localparam logic [2:0] RSVD  = 3'b111;

  localparam int K_DONE = 0;
  localparam int K_INV  = 1;
  localparam int K_DZ   = 2;
  localparam int K_MULTI = 9;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] num1 = 32'd0;
  logic [31:0] num2 = 32'd0;
  logic [2:0]  op = 3'd0;
  logic        start = 1'b0;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        op_invalid;
  logic        div_zero;

  always #5 clk = ~clk;

  mdu dut (
    .clk        (clk),
    .reset      (reset),
    .num1       (num1),
    .num2       (num2),
    .op         (op),
    .start      (start),
    .hi         (hi),
    .lo         (lo),
    .busy       (busy),
    .done       (done),
    .op_invalid (op_invalid),
    .div_zero   (div_zero)
  );

  typedef struct {
    int          kind;
    logic [31:0] hi;
    logic [31:0] lo;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic string opname(input logic [2:0] o);
    case (o)
      NONE:    return "NONE";
      MULT:    return "MULT";
      MULTU:   return "MULTU";
      DIV:     return "DIV";
      DIVU:    return "DIVU";
      MTHI:    return "MTHI";
      MTLO:    return "MTLO";
      default: return "RSVD";
    endcase
  endfunction

  function automatic logic [31:0] rnd_operand();
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0:       v = 32'd0;
      1:       v = 32'hFFFF_FFFF;
      2:       v = 32'h8000_0000;
      3:       v = $urandom_range(0, 20);
      default: v = $urandom;
    endcase
    return v;
  endfunction

  // Monitor: each strobe pulse must match the oldest queued expectation.
  initial begin
    int   kind;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && (done || op_invalid || div_zero)) begin
        if ($countones({done, op_invalid, div_zero}) > 1) kind = K_MULTI;
        else if (done)                                    kind = K_DONE;
        else if (op_invalid)                              kind = K_INV;
        else                                              kind = K_DZ;
        chk("strobe_was_expected", (sb.size() != 0), 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk({e.name, "_strobe_kind"}, kind, e.kind);
          chk({e.name, "_hi"}, hi, e.hi);
          chk({e.name, "_lo"}, lo, e.lo);
        end
      end
    end
  end

  // Issue one operation from a negedge and return at a negedge once idle.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    int          n;
    int          exp_busy;
    logic [31:0] n_hi;
    logic [31:0] n_lo;
    longint      sa, sb_, sq, sr;
    longint unsigned up;
    exp_t        e;
    bit          writes;

    n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("idle_before_issue", busy, 0);

    exp_busy = 0;
    writes   = 1'b0;
    n_hi     = m_hi;
    n_lo     = m_lo;
    e.name   = opname(o);
    case (o)
      MULT: begin
        sa = longint'($signed(a));
        sb_ = longint'($signed(b));
        sq = sa * sb_;
        n_hi = sq[63:32];
        n_lo = sq[31:0];
        writes = 1'b1;
        exp_busy = 5;
      end
      MULTU: begin
        up = {32'd0, a} * {32'd0, b};
        n_hi = up[63:32];
        n_lo = up[31:0];
        writes = 1'b1;
        exp_busy = 5;
      end
      DIV, DIVU: begin
        if (b == 32'd0) begin
`ifdef MDU_DIV_ZERO_EN
          e.kind = K_DZ;
          e.hi = m_hi;
          e.lo = m_lo;
          sb.push_back(e);
`else
          n_lo = 32'hFFFF_FFFF;
          n_hi = a;
          writes = 1'b1;
          exp_busy = 10;
`endif
        end else if (o == DIV) begin
          sa = longint'($signed(a));
          sb_ = longint'($signed(b));
          sq = sa / sb_;
          sr = sa % sb_;
          n_lo = sq[31:0];
          n_hi = sr[31:0];
          writes = 1'b1;
          exp_busy = 10;
        end else begin
          n_lo = a / b;
          n_hi = a % b;
          writes = 1'b1;
          exp_busy = 10;
        end
      end
      MTHI: m_hi = a;
      MTLO: m_lo = a;
      RSVD: begin
        e.kind = K_INV;
        e.hi = m_hi;
        e.lo = m_lo;
        sb.push_back(e);
      end
      default: ;
    endcase
    if (writes) begin
      e.kind = K_DONE;
      e.hi = n_hi;
      e.lo = n_lo;
      sb.push_back(e);
    end

    start = 1'b1;
    op = o;
    num1 = a;
    num2 = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    op = 3'($urandom_range(0, 7));
    num1 = $urandom;
    num2 = $urandom;
    chk({e.name, "_hi_at_accept"}, hi, m_hi);
    chk({e.name, "_lo_at_accept"}, lo, m_lo);

    @(negedge clk);
    n = 0;
    while (busy && n < 40) begin
      n++;
      if (hi !== m_hi || lo !== m_lo) begin
        chk({e.name, "_hilo_hold_while_busy"}, {hi, lo}, {m_hi, m_lo});
      end
      num1 = $urandom;
      num2 = $urandom;
      if (n == 2) begin
        start = 1'b1;
        op = 3'($urandom_range(0, 7));
        @(posedge clk);
        #1;
        start = 1'b0;
      end
      @(negedge clk);
    end
    chk({e.name, "_busy_cycles"}, n, exp_busy);
    if (writes) begin
      m_hi = n_hi;
      m_lo = n_lo;
    end
    chk({e.name, "_hi_final"}, hi, m_hi);
    chk({e.name, "_lo_final"}, lo, m_lo);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_hi", hi, 0);
    chk("reset_lo", lo, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_op_invalid", op_invalid, 0);
    chk("reset_div_zero", div_zero, 0);
    reset = 1'b0;
    @(negedge clk);

    issue(MULT, 32'hFFFF_FFFE, 32'd3);
    chk("mult_neg2x3_hi", hi, 32'hFFFF_FFFF);
    chk("mult_neg2x3_lo", lo, 32'hFFFF_FFFA);
    issue(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("multu_max_hi", hi, 32'hFFFF_FFFE);
    chk("multu_max_lo", lo, 32'h0000_0001);
    issue(DIV, 32'hFFFF_FFF9, 32'd2);
    chk("div_m7_2_lo", lo, 32'hFFFF_FFFD);
    chk("div_m7_2_hi", hi, 32'hFFFF_FFFF);
    issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("div_ovf_lo", lo, 32'h8000_0000);
    chk("div_ovf_hi", hi, 32'h0);
    issue(DIVU, 32'd100, 32'd0);
    issue(DIV, 32'hFFFF_FF00, 32'd0);
    issue(MTHI, 32'hCAFE_0001, 32'd5);
    issue(NONE, 32'h1111_1111, 32'h2222_2222);
    issue(RSVD, 32'h3333_3333, 32'h4444_4444);

    for (int i = 0; i < 80; i++) begin
      issue(3'($urandom_range(0, 7)), rnd_operand(), rnd_operand());
    end

    // Make sure HI/LO hold nonzero values, so the reset checks below can fail.
    issue(MTHI, 32'hA5A5_A5A5, 32'd0);
    issue(MTLO, 32'h5A5A_5A5A, 32'd0);

    // Abort a MULT with reset. The second start must be ignored, and no done may follow.
    start = 1'b1;
    op = MULT;
    num1 = 32'hFFFF_FFFE;
    num2 = 32'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    chk("abort_busy_cycle1", busy, 1);
    @(negedge clk);
    start = 1'b1;
    op = DIV;
    num1 = 32'd77;
    num2 = 32'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("abort_hi_cleared", hi, 0);
    chk("abort_lo_cleared", lo, 0);
    chk("abort_busy_cleared", busy, 0);
    m_hi = 32'd0;
    m_lo = 32'd0;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (busy !== 1'b0) chk("abort_stays_idle", busy, 0);
    end
    chk("abort_hi_after", hi, 0);
    chk("abort_lo_after", lo, 0);
    issue(MTLO, 32'h0000_1234, 32'd0);
    chk("mtlo_after_abort", lo, 32'h0000_1234);
    issue(RSVD, 32'd9, 32'd9);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
